// File: rtl/cmd_arbiter.sv
// Arbitrates the single cmd_proc command port between the buffered UART host and the tour sequencer.
// Runs the cmd_rdy/clr/send_resp handshake, builds the A5/5A/EE response and aborts stalled commands.
module cmd_arbiter #(
  parameter int UQ_DEPTH = 4,
  parameter int TMO_CYC  = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] uart_cmd,
  input  logic        uart_cmd_rdy,
  output logic        uart_clr_cmd_rdy,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  input  logic        tour_last,
  output logic        tour_clr_cmd_rdy,
  output logic        tour_send_resp,
  output logic        tour_abort,
  output logic        tour_busy,
  output logic [15:0] proc_cmd,
  output logic        proc_cmd_rdy,
  input  logic        proc_clr_cmd_rdy,
  input  logic        proc_send_resp,
  output logic [7:0]  resp,
  output logic        resp_vld
);

  localparam int PW = $clog2(UQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TMO_CYC);
  localparam logic [WW-1:0] WD_MAX   = WW'(TMO_CYC - 1);
  localparam logic [7:0]    RESP_OK  = 8'hA5;
  localparam logic [7:0]    RESP_MID = 8'h5A;
  localparam logic [7:0]    RESP_TMO = 8'hEE;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [UQ_DEPTH];
  logic [15:0]   mem_d [UQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          uart_clr_q, uart_clr_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          src_tour_q, src_tour_d;
  logic          last_q, last_d;
  logic          tour_busy_q, tour_busy_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    resp_code_q, resp_code_d;
  logic          timeout_q, timeout_d;
  logic          full, empty, push, pop, tour_grant;

  // The registered clr blocks a second push while the UART still holds its request.
  always_comb begin
    full       = (count_q == CW'(UQ_DEPTH));
    empty      = (count_q == '0);
    push       = uart_cmd_rdy && !full && !uart_clr_q;
    uart_clr_d = push;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = uart_cmd;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    src_tour_d  = src_tour_q;
    last_d      = last_q;
    tour_busy_d = tour_busy_q;
    wd_d        = wd_q;
    resp_code_d = resp_code_q;
    timeout_d   = timeout_q;
    pop         = 1'b0;
    tour_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        // A tour in progress locks out the UART even between tour moves.
        if (!rst && tour_cmd_rdy) begin
          tour_grant  = 1'b1;
          cmd_d       = tour_cmd;
          src_tour_d  = 1'b1;
          last_d      = tour_last;
          tour_busy_d = 1'b1;
          state_d     = ISSUE;
        end else if (!rst && !tour_busy_q && !empty) begin
          pop        = 1'b1;
          cmd_d      = mem_q[rd_ptr_q];
          src_tour_d = 1'b0;
          last_d     = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (proc_clr_cmd_rdy) begin
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (proc_send_resp) begin
          resp_code_d = (!src_tour_q || last_q) ? RESP_OK : RESP_MID;
          timeout_d   = 1'b0;
          state_d     = RESP;
        end else if (wd_q == WD_MAX) begin
          resp_code_d = RESP_TMO;
          timeout_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (src_tour_q && (last_q || timeout_q)) tour_busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_clr_cmd_rdy = uart_clr_q;
    tour_clr_cmd_rdy = tour_grant;
    tour_busy        = tour_busy_q;
    proc_cmd_rdy     = (state_q == ISSUE);
    proc_cmd         = (state_q == ISSUE) ? cmd_q : 16'h0000;
    resp_vld         = (state_q == RESP);
    resp             = (state_q == RESP) ? resp_code_q : 8'h00;
    tour_send_resp   = (state_q == RESP) && src_tour_q;
    tour_abort       = (state_q == RESP) && src_tour_q && timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      uart_clr_q  <= 1'b0;
      cmd_q       <= '0;
      src_tour_q  <= 1'b0;
      last_q      <= 1'b0;
      tour_busy_q <= 1'b0;
      wd_q        <= '0;
      resp_code_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      uart_clr_q  <= uart_clr_d;
      cmd_q       <= cmd_d;
      src_tour_q  <= src_tour_d;
      last_q      <= last_d;
      tour_busy_q <= tour_busy_d;
      wd_q        <= wd_d;
      resp_code_q <= resp_code_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: acts as UART wrapper, tour sequencer and cmd_proc,
// and checks every handshake and response against hand-computed values.
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] uart_cmd;
  logic        uart_cmd_rdy;
  logic        uart_clr_cmd_rdy;
  logic [15:0] tour_cmd;
  logic        tour_cmd_rdy;
  logic        tour_last;
  logic        tour_clr_cmd_rdy;
  logic        tour_send_resp;
  logic        tour_abort;
  logic        tour_busy;
  logic [15:0] proc_cmd;
  logic        proc_cmd_rdy;
  logic        proc_clr_cmd_rdy;
  logic        proc_send_resp;
  logic [7:0]  resp;
  logic        resp_vld;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int uclr_cnt  = 0;
  int rvld_cnt  = 0;

  cmd_arbiter #(.UQ_DEPTH(4), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy), .uart_clr_cmd_rdy(uart_clr_cmd_rdy),
    .tour_cmd(tour_cmd), .tour_cmd_rdy(tour_cmd_rdy), .tour_last(tour_last),
    .tour_clr_cmd_rdy(tour_clr_cmd_rdy), .tour_send_resp(tour_send_resp),
    .tour_abort(tour_abort), .tour_busy(tour_busy),
    .proc_cmd(proc_cmd), .proc_cmd_rdy(proc_cmd_rdy),
    .proc_clr_cmd_rdy(proc_clr_cmd_rdy), .proc_send_resp(proc_send_resp),
    .resp(resp), .resp_vld(resp_vld)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, used to catch lost or duplicated handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_clr_cmd_rdy) uclr_cnt++;
      if (resp_vld) rvld_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed hang, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus;
    uart_cmd         = '0;
    uart_cmd_rdy     = 1'b0;
    tour_cmd         = '0;
    tour_cmd_rdy     = 1'b0;
    tour_last        = 1'b0;
    proc_clr_cmd_rdy = 1'b0;
    proc_send_resp   = 1'b0;
  endtask

  task automatic uartSend(input logic [15:0] cmd);
    int n = 0;
    uart_cmd     = cmd;
    uart_cmd_rdy = 1'b1;
    do begin
      tick;
      n++;
    end while (!uart_clr_cmd_rdy && n < 20);
    checkOutput("uart_clr", {15'd0, uart_clr_cmd_rdy}, 16'd1);
    uart_cmd_rdy = 1'b0;
  endtask

  task automatic tourSend(input logic [15:0] cmd, input logic last);
    int n = 0;
    tour_cmd     = cmd;
    tour_last    = last;
    tour_cmd_rdy = 1'b1;
    #1;
    while (!tour_clr_cmd_rdy && n < 20) begin
      tick;
      n++;
    end
    checkOutput("tour_clr", {15'd0, tour_clr_cmd_rdy}, 16'd1);
    tick;
    tour_cmd_rdy = 1'b0;
  endtask

  // cmd_proc model: accept after clr_dly cycles, finish after resp_dly further cycles.
  task automatic procServe(input int clr_dly, input int resp_dly, input logic [7:0] exp_resp,
                           input logic exp_tsr, input string tag, output logic [15:0] seen);
    int n = 0;
    while (!proc_cmd_rdy && n < 20) begin
      tick;
      n++;
    end
    checkOutput({tag, "_cmd_rdy"}, {15'd0, proc_cmd_rdy}, 16'd1);
    seen = proc_cmd;
    repeat (clr_dly) tick;
    proc_clr_cmd_rdy = 1'b1;
    tick;
    proc_clr_cmd_rdy = 1'b0;
    checkOutput({tag, "_rdy_drop"}, {15'd0, proc_cmd_rdy}, 16'd0);
    repeat (resp_dly) tick;
    proc_send_resp = 1'b1;
    tick;
    proc_send_resp = 1'b0;
    #1;
    checkOutput({tag, "_resp_vld"}, {15'd0, resp_vld}, 16'd1);
    checkOutput({tag, "_resp"}, {8'd0, resp}, {8'd0, exp_resp});
    checkOutput({tag, "_tour_send_resp"}, {15'd0, tour_send_resp}, {15'd0, exp_tsr});
    checkOutput({tag, "_tour_abort"}, {15'd0, tour_abort}, 16'd0);
    tick;
    checkOutput({tag, "_resp_vld_pulse"}, {15'd0, resp_vld}, 16'd0);
  endtask

  initial begin
    logic [15:0] seen;
    int          base;
    int          n;

    applyStimulus;
    rst = 1'b1;
    tick;
    tick;
    checkOutput("rst_proc_cmd_rdy", {15'd0, proc_cmd_rdy}, 16'd0);
    checkOutput("rst_proc_cmd", proc_cmd, 16'd0);
    checkOutput("rst_resp_vld", {15'd0, resp_vld}, 16'd0);
    checkOutput("rst_resp", {8'd0, resp}, 16'd0);
    checkOutput("rst_tour_busy", {15'd0, tour_busy}, 16'd0);
    checkOutput("rst_uart_clr", {15'd0, uart_clr_cmd_rdy}, 16'd0);
    checkOutput("rst_tour_clr", {15'd0, tour_clr_cmd_rdy}, 16'd0);
    rst = 1'b0;
    tick;

    $display("[TB] T1 single UART command");
    proc_send_resp = 1'b1;
    tick;
    proc_send_resp = 1'b0;
    #1;
    checkOutput("t1_stray_send_resp", {15'd0, resp_vld}, 16'd0);
    uartSend(16'h2004);
    procServe(3, 10, 8'hA5, 1'b0, "t1", seen);
    checkOutput("t1_proc_cmd", seen, 16'h2004);
    checkOutput("t1_uart_clr_count", 16'(uclr_cnt), 16'd1);
    checkOutput("t1_resp_vld_count", 16'(rvld_cnt), 16'd1);

    $display("[TB] T2 tour with UART commands queued mid-tour");
    tourSend(16'h1111, 1'b0);
    checkOutput("t2_tour_busy_set", {15'd0, tour_busy}, 16'd1);
    uartSend(16'hA001);
    uartSend(16'hA002);
    procServe(2, 3, 8'h5A, 1'b1, "t2a", seen);
    checkOutput("t2a_cmd", seen, 16'h1111);
    checkOutput("t2_tour_busy_hold", {15'd0, tour_busy}, 16'd1);
    tick;
    checkOutput("t2_uart_locked_out_1", {15'd0, proc_cmd_rdy}, 16'd0);
    tick;
    checkOutput("t2_uart_locked_out_2", {15'd0, proc_cmd_rdy}, 16'd0);
    tourSend(16'h2222, 1'b0);
    procServe(1, 2, 8'h5A, 1'b1, "t2b", seen);
    checkOutput("t2b_cmd", seen, 16'h2222);
    tourSend(16'h3333, 1'b1);
    procServe(1, 2, 8'hA5, 1'b1, "t2c", seen);
    checkOutput("t2c_cmd", seen, 16'h3333);
    checkOutput("t2_tour_busy_clear", {15'd0, tour_busy}, 16'd0);
    procServe(1, 1, 8'hA5, 1'b0, "t2d", seen);
    checkOutput("t2d_cmd", seen, 16'hA001);
    procServe(1, 1, 8'hA5, 1'b0, "t2e", seen);
    checkOutput("t2e_cmd", seen, 16'hA002);

    $display("[TB] T3 FIFO overflow backpressure during tour");
    tourSend(16'h4444, 1'b0);
    procServe(1, 1, 8'h5A, 1'b1, "t3t", seen);
    base = uclr_cnt;
    uartSend(16'hB001);
    uartSend(16'hB002);
    uartSend(16'hB003);
    uartSend(16'hB004);
    uart_cmd     = 16'hB005;
    uart_cmd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("t3_full_no_clr", {15'd0, uart_clr_cmd_rdy}, 16'd0);
    end
    checkOutput("t3_four_clr", 16'(uclr_cnt - base), 16'd4);
    tourSend(16'h5555, 1'b1);
    procServe(1, 1, 8'hA5, 1'b1, "t3u", seen);
    checkOutput("t3u_cmd", seen, 16'h5555);
    checkOutput("t3_no_clr_before_pop", {15'd0, uart_clr_cmd_rdy}, 16'd0);
    tick;
    checkOutput("t3_no_clr_at_pop", {15'd0, uart_clr_cmd_rdy}, 16'd0);
    tick;
    checkOutput("t3_clr_after_pop", {15'd0, uart_clr_cmd_rdy}, 16'd1);
    uart_cmd_rdy = 1'b0;
    procServe(1, 1, 8'hA5, 1'b0, "t3a", seen);
    checkOutput("t3a_cmd", seen, 16'hB001);
    procServe(1, 1, 8'hA5, 1'b0, "t3b", seen);
    checkOutput("t3b_cmd", seen, 16'hB002);
    procServe(1, 1, 8'hA5, 1'b0, "t3c", seen);
    checkOutput("t3c_cmd", seen, 16'hB003);
    procServe(1, 1, 8'hA5, 1'b0, "t3d", seen);
    checkOutput("t3d_cmd", seen, 16'hB004);
    procServe(1, 1, 8'hA5, 1'b0, "t3e", seen);
    checkOutput("t3e_cmd", seen, 16'hB005);
    checkOutput("t3_five_clr", 16'(uclr_cnt - base), 16'd5);
    tick;
    tick;
    checkOutput("t3_fifo_drained", {15'd0, proc_cmd_rdy}, 16'd0);

    $display("[TB] T4 watchdog abort of a tour command");
    tourSend(16'h6666, 1'b0);
    proc_clr_cmd_rdy = 1'b1;
    tick;
    proc_clr_cmd_rdy = 1'b0;
    n = 1;
    while (!resp_vld && n < 40) begin
      tick;
      n++;
    end
    checkOutput("t4_abort_cycle", 16'(n), 16'd17);
    checkOutput("t4_resp", {8'd0, resp}, 16'h00EE);
    checkOutput("t4_tour_abort", {15'd0, tour_abort}, 16'd1);
    checkOutput("t4_tour_send_resp", {15'd0, tour_send_resp}, 16'd1);
    tick;
    checkOutput("t4_tour_busy_clear", {15'd0, tour_busy}, 16'd0);
    checkOutput("t4_abort_pulse", {15'd0, tour_abort}, 16'd0);

    $display("[TB] T5 tour beats queued UART in IDLE");
    uartSend(16'hC001);
    tick;
    uartSend(16'hC002);
    tour_cmd     = 16'h7777;
    tour_last    = 1'b1;
    tour_cmd_rdy = 1'b1;
    procServe(1, 2, 8'hA5, 1'b0, "t5a", seen);
    checkOutput("t5a_cmd", seen, 16'hC001);
    checkOutput("t5_tour_wins", {15'd0, tour_clr_cmd_rdy}, 16'd1);
    tick;
    tour_cmd_rdy = 1'b0;
    checkOutput("t5_tour_issued", proc_cmd, 16'h7777);
    procServe(1, 1, 8'hA5, 1'b1, "t5b", seen);
    procServe(1, 1, 8'hA5, 1'b0, "t5c", seen);
    checkOutput("t5c_cmd", seen, 16'hC002);

    $display("[TB] T6 reset while busy with queued commands");
    tourSend(16'h8888, 1'b0);
    uartSend(16'hD001);
    uartSend(16'hD002);
    proc_clr_cmd_rdy = 1'b1;
    tick;
    proc_clr_cmd_rdy = 1'b0;
    tick;
    tick;
    base = rvld_cnt;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    checkOutput("t6_proc_cmd_rdy", {15'd0, proc_cmd_rdy}, 16'd0);
    checkOutput("t6_proc_cmd", proc_cmd, 16'd0);
    checkOutput("t6_resp_vld", {15'd0, resp_vld}, 16'd0);
    checkOutput("t6_resp", {8'd0, resp}, 16'd0);
    checkOutput("t6_tour_busy", {15'd0, tour_busy}, 16'd0);
    checkOutput("t6_uart_clr", {15'd0, uart_clr_cmd_rdy}, 16'd0);
    checkOutput("t6_tour_flags", {14'd0, tour_send_resp, tour_abort}, 16'd0);
    repeat (4) tick;
    checkOutput("t6_fifo_empty", {15'd0, proc_cmd_rdy}, 16'd0);
    checkOutput("t6_no_resp", 16'(rvld_cnt - base), 16'd0);
    uartSend(16'hE001);
    procServe(1, 1, 8'hA5, 1'b0, "t6e", seen);
    checkOutput("t6e_cmd", seen, 16'hE001);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
